// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver with 3-sample mid-bit majority voting.
// Received bytes are delivered through a valid/ready holding register.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int unsigned H  = CLKS_PER_BIT / 2;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_SMP_A = CW'(H - 1);
    localparam logic [CW-1:0] CNT_SMP_B = CW'(H);
    localparam logic [CW-1:0] CNT_DEC   = CW'(H + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          smp_a;
    logic          smp_b;
    logic          maj_c;
    logic          deliver_c;

    // Two-flop synchronizer; idles high so reset looks like an idle line.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // Third sample is the live synchronized value at the decision point.
    assign maj_c     = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
    assign deliver_c = (state == STOP) && (cnt == CNT_DEC) && maj_c;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            smp_a       <= 1'b0;
            smp_b       <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            if (cnt == CNT_SMP_A) smp_a <= rx_s;
            if (cnt == CNT_SMP_B) smp_b <= rx_s;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state  <= START;
                        o_busy <= 1'b1;
                    end
                end

                START: begin
                    if ((cnt == CNT_DEC) && maj_c) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        o_busy <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= DATA;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == CNT_DEC) shreg <= {maj_c, shreg[7:1]};
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) state <= STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Leave at mid stop bit so a back-to-back start edge is not missed.
                STOP: begin
                    if (cnt == CNT_DEC) begin
                        cnt <= '0;
                        if (maj_c) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            state       <= WAIT_IDLE;
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_IDLE: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // Holding register: a same-cycle handshake frees the slot for the new byte.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (deliver_c) begin
                if (!o_valid || i_ready) begin
                    o_data  <= shreg;
                    o_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Randomized and directed bench for uart_rx_byte at CLKS_PER_BIT=16.
// A byte queue plus pulse counters model what the receiver must deliver.
module tb_uart_rx_byte;

    localparam int unsigned C = 16;
    localparam int unsigned H = C / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_rx       (rx),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (ready),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         ferr_exp = 0, ferr_seen = 0;
    int         ovr_exp = 0, ovr_seen = 0;
    int         t0 = 0;
    bit         lat_armed = 0;
    bit         hs_prev = 0;
    bit         v_prev = 0;
    logic [7:0] d_prev = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle: handshakes pop the model queue, pulses are tallied, held data must not move.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (v_prev && !hs_prev) check("data_stable", {o_valid, o_data}, {1'b1, d_prev});
            if (o_valid && !v_prev && lat_armed) begin
                check("latency_window",
                      32'((cyc - t0 >= int'(9*C+H+2)) && (cyc - t0 <= int'(9*C+H+5))), 32'd1);
                lat_armed = 0;
            end
            if (o_valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", o_data);
                end else begin
                    check("byte", o_data, exp_q.pop_front());
                end
            end
            if (o_frame_err) ferr_seen++;
            if (o_overrun) ovr_seen++;
        end
        hs_prev = rst_n && o_valid && ready;
        v_prev  = rst_n && o_valid;
        d_prev  = o_data;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    // One 8N1 frame; optional single-cycle inversion at bit gbit, offset goff.
    task automatic send(input logic [7:0] b, input bit stop, input bit push,
                        input int gbit, input int goff, input bit arm);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        if (push) begin
            if (stop) exp_q.push_back(b);
            else ferr_exp++;
        end
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < int'(C); k++) begin
                @(negedge clk);
                rx = (i == gbit && k == goff) ? ~fr[i] : fr[i];
                if (i == 0 && k == 0 && arm) begin
                    t0 = cyc;
                    lat_armed = 1;
                end
                if (i == 5 && k == int'(H)) begin
                    #2;
                    check("busy_mid_frame", o_busy, 1);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, o_data, 0);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_frame_err"}, o_frame_err, 0);
        check({tag, "_overrun"}, o_overrun, 0);
        check({tag, "_busy"}, o_busy, 0);
    endtask

    initial begin
        logic [9:0] fr;
        bit         aborted;
        int         gbit, goff, gap;
        logic [7:0] b;
        bit         stop;

        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2 * C);

        // Single frame with latency window
        send(8'hA5, 1, 1, -1, 0, 1);
        idle(2 * C);
        #2;
        check("a5_data_literal", o_data, 8'hA5);
        check("a5_valid_consumed", o_valid, 0);
        check("a5_no_frame_err", ferr_seen, 0);
        check("a5_no_overrun", ovr_seen, 0);

        // Back-to-back frames with 1-bit and 0-bit gaps
        send(8'h02, 1, 1, -1, 0, 0);
        idle(C);
        #2;
        check("busy_between_frames", o_busy, 0);
        send(8'h04, 1, 1, -1, 0, 0);
        send(8'h00, 1, 1, -1, 0, 0);
        idle(C);
        send(8'h0A, 1, 1, -1, 0, 0);
        idle(2 * C);
        #2;
        check("b2b_busy_after", o_busy, 0);
        check("b2b_queue_drained", exp_q.size(), 0);

        // Framing error followed by a held-low break
        send(8'h3C, 0, 1, -1, 0, 0);
        repeat (40) begin
            @(negedge clk);
            rx = 1'b0;
        end
        #2;
        check("break_busy_wait_idle", o_busy, 1);
        check("frame_err_once", ferr_seen, 1);
        idle(2 * C);
        #2;
        check("break_released_busy", o_busy, 0);
        send(8'h55, 1, 1, -1, 0, 0);
        idle(2 * C);

        // Short low glitch is a false start
        repeat (5) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle(C);
        #2;
        check("false_start_busy", o_busy, 0);
        check("false_start_no_valid", o_valid, 0);

        // Single-cycle inversion at the middle sample of data bit 3
        send(8'h00, 1, 1, 4, H + 1, 0);
        idle(2 * C);

        // Overrun with consumer stalled
        @(negedge clk);
        ready = 1'b0;
        send(8'h11, 1, 1, -1, 0, 0);
        idle(C);
        send(8'h22, 1, 0, -1, 0, 0);
        ovr_exp++;
        idle(C);
        #2;
        check("ovr_valid_held", o_valid, 1);
        check("ovr_data_kept", o_data, 8'h11);
        check("ovr_pulse_once", ovr_seen, 1);
        @(negedge clk);
        ready = 1'b1;
        idle(2);
        #2;
        check("ovr_valid_cleared", o_valid, 0);

        // Reset asserted during data bit 4
        fr = {1'b1, 8'hFF, 1'b0};
        aborted = 0;
        for (int i = 0; i < 10 && !aborted; i++) begin
            for (int k = 0; k < int'(C) && !aborted; k++) begin
                @(negedge clk);
                if (i == 5 && k == int'(H)) begin
                    rst_n = 1'b0;
                    aborted = 1;
                end else begin
                    rx = fr[i];
                end
            end
        end
        #1;
        check_all_zero("midframe_reset");
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2 * C);
        send(8'h81, 1, 1, -1, 0, 0);
        idle(2 * C);

        // Randomized frames, gaps, glitches and framing errors
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 9) != 0);
            gbit = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 8)) : -1;
            goff = int'($urandom_range(3, C - 4));
            send(b, stop, 1, gbit, goff, 0);
            gap = stop ? int'($urandom_range(0, 2 * C)) : int'($urandom_range(C, 2 * C));
            idle(gap);
        end
        idle(3 * C);
        #2;
        check("final_queue_empty", exp_q.size(), 0);
        check("final_frame_err_count", ferr_seen, ferr_exp);
        check("final_overrun_count", ovr_seen, ovr_exp);
        check("final_busy", o_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART 8N1 receiver that sits directly upstream of the protocol handler.
- Converts the serial host line into a stream of bytes: debugger commands, addresses, lengths and payload.
- Bytes are delivered through a valid/ready holding register. Framing errors and overruns are reported as single-cycle flags.
- Uses 3-sample majority voting at mid-bit for noise rejection.

Parameters:
- CLKS_PER_BIT, 868, i_clk cycles per UART bit (100 MHz / 115200). Legal range is >= 8.
- H (localparam), CLKS_PER_BIT/2 (floor), mid-bit sample index.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_rx  in  1  asynchronous serial line; idles high.
- o_data  out  8  received byte; stable while o_valid=1.
- o_valid  out  1  holding register contains an unconsumed byte.
- i_ready  in  1  consumer accepts the byte when o_valid&&i_ready.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled 0; byte discarded.
- o_overrun  out  1  one-cycle pulse: byte completed while holding register full; new byte discarded.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release):
  - o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0.
  - Both synchronizer flops=1, state=IDLE, counters=0, shift register=0.
- Input sync: i_rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only.
- Bit timing:
  - cnt runs 0..CLKS_PER_BIT-1 within each bit and wraps to 0 at the bit boundary.
  - Samples are taken at cnt=H-1, H, H+1. The bit value is the majority of the 3 samples, decided at cnt=H+1.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when rx_s=0, go to START with cnt=0.
  - START: at the decision point, majority 1 is a false start → IDLE. Majority 0 → continue; go to DATA at the bit boundary with bit_idx=0.
  - DATA: at each decision, shift the bit into the shift register LSB-first. After bit_idx=7 reaches its bit boundary, go to STOP.
  - STOP, majority 1: deliver the byte (see holding-register rules) and go to IDLE immediately at the decision point. The half-bit early return allows back-to-back frames.
  - STOP, majority 0: pulse o_frame_err for 1 cycle, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents a break condition from retriggering frames.
- Holding register:
  - Delivery with o_valid=0: o_data<=byte, o_valid<=1 next cycle.
  - o_valid&&i_ready with no delivery in the same cycle: o_valid<=0. o_data holds its last value.
  - Delivery and handshake in the same cycle: load the new byte; o_valid stays 1.
  - Delivery with o_valid=1 and no handshake: keep the old byte, discard the new one, pulse o_overrun for 1 cycle.
- Latency: o_valid rises between 9*CLKS_PER_BIT+H+2 and 9*CLKS_PER_BIT+H+5 cycles after i_rx falls at the start edge.
- Glitch rejection: a low pulse on i_rx shorter than H-1 cycles never produces o_valid.
- Single-cycle noise: a one-cycle inversion at any single sample point inside a bit does not change the decided value.
- No parity, fixed 8 data bits, 1 stop bit. i_ready is ignored while o_valid=0.
- Reset asserted mid-frame: everything returns to reset values immediately and any partial byte is lost. After release, the next full frame is received correctly.

Test Plan (CLKS_PER_BIT=16):
- Frame 0xA5 with i_ready=1 → exactly one o_valid cycle with o_data=0xA5 and no error pulses. Latency falls within the stated window.
- Frames 0x02, 0x04, 0x00, 0x0A back-to-back, with idle time of 1 bit then 0 bits, i_ready=1 → four valid handshakes in order; o_busy low only between frames.
- Frame 0x3C with stop bit forced 0, then line held low for 40 cycles, then 0x55 → o_frame_err pulses once and no valid for 0x3C. FSM waits in WAIT_IDLE; 0x55 is then delivered.
- i_rx low for 5 cycles, then high → no o_valid; o_busy returns low.
- One-cycle high glitch at cnt=H of data bit 3 in frame 0x00 → o_data=0x00.
- Frames 0x11 then 0x22 with i_ready=0 → o_valid=1 with o_data=0x11 and one o_overrun pulse at the 0x22 stop. Raising i_ready clears o_valid.
- i_reset_n pulsed low during data bit 4 of frame 0xFF → all outputs 0 at once. The following frame 0x81 is received as 0x81.
